// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO between the UART receiver and the bus, with occupancy RTS
module uart_rx_fifo #(
   parameter  int PAYLOAD_BITS = 8,
   parameter  int DEPTH        = 4,
   localparam int LEVEL_BITS   = $clog2(DEPTH) + 1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_uart_rx_valid,
   input  logic [PAYLOAD_BITS-1:0] i_uart_rx_data,
   output logic                    o_uart_rx_read,
   input  logic                    i_flush,
   output logic [PAYLOAD_BITS-1:0] o_out_data,
   output logic                    o_out_valid,
   input  logic                    i_out_read,
   output logic [LEVEL_BITS-1:0]   o_level,
   output logic                    o_fifo_rts,
   output logic                    o_underflow
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam logic [LEVEL_BITS-1:0] LVL_FULL = LEVEL_BITS'(DEPTH);
   localparam logic [LEVEL_BITS-1:0] LVL_RTS  = LEVEL_BITS'(DEPTH - 1);
   localparam logic [LEVEL_BITS-1:0] LVL_ONE  = LEVEL_BITS'(1);
   localparam logic [PTR_BITS-1:0]   PTR_ONE  = PTR_BITS'(1);

   logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
   logic [PTR_BITS-1:0]     r_wr_ptr;
   logic [PTR_BITS-1:0]     r_rd_ptr;
   logic [LEVEL_BITS-1:0]   r_level;
   logic                    r_rx_read;
   logic                    r_rts;
   logic                    r_underflow;

   logic [LEVEL_BITS-1:0]   w_level_nxt;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;

   // Full/empty come from the occupancy count only; pointers are free to wrap.
   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);

   // The registered read pulse masks the cycle where the receiver still shows the byte just taken.
   assign w_push = i_uart_rx_valid & ~w_full & ~r_rx_read & ~i_flush;
   assign w_pop  = i_out_read & ~w_empty & ~i_flush;

   assign o_uart_rx_read = r_rx_read;
   assign o_out_data     = r_mem[r_rd_ptr];
   assign o_out_valid    = ~w_empty;
   assign o_level        = r_level;
   assign o_fifo_rts     = r_rts;
   assign o_underflow    = r_underflow;

   // Next occupancy; shared by the level register and the RTS register so both move together.
   always_comb begin
      w_level_nxt = r_level;
      if (i_flush) begin
         w_level_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_level_nxt = r_level + LVL_ONE;
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LVL_ONE;
      end
   end

   // Pointers, occupancy, receiver handshake and status flags.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_rx_read   <= 1'b0;
         r_rts       <= 1'b1;
         r_underflow <= 1'b0;
      end else begin
         r_rx_read <= w_push;
         r_level   <= w_level_nxt;
         r_rts     <= (w_level_nxt >= LVL_RTS);
         if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_underflow <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (i_out_read && w_empty) begin
               r_underflow <= 1'b1;
            end
         end
      end
   end

   // Byte storage; contents need no reset because out_valid qualifies them.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_uart_rx_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with a holding receiver model
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       flush;
   logic       out_read;
   logic       o_uart_rx_read;
   logic [7:0] o_out_data;
   logic       o_out_valid;
   logic [2:0] o_level;
   logic       o_fifo_rts;
   logic       o_underflow;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb [$];
   logic [7:0] rx_q [$];
   logic       rd_seen = 1'b0;
   int         pulses = 0;
   int         lvl_max;

   always #5 clk = ~clk;

   uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(4)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_uart_rx_valid (rx_valid),
      .i_uart_rx_data  (rx_data),
      .o_uart_rx_read  (o_uart_rx_read),
      .i_flush         (flush),
      .o_out_data      (o_out_data),
      .o_out_valid     (o_out_valid),
      .i_out_read      (out_read),
      .o_level         (o_level),
      .o_fifo_rts      (o_fifo_rts),
      .o_underflow     (o_underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_q.push_back(b);
      sb.push_back(b);
   endtask

   task automatic wait_level(input int target);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_level == target) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_level: level %0d never reached %0d", o_level, target);
   endtask

   task automatic drain();
      out_read = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!o_out_valid) break;
      end
      out_read = 1'b0;
   endtask

   task automatic track_level();
      if (o_level > lvl_max) lvl_max = o_level;
   endtask

   // Receiver: holds a byte until it has seen a read pulse, then presents the next queued byte.
   initial begin
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rx_valid && rd_seen) rx_valid = 1'b0;
         if (!rx_valid && rx_q.size() > 0) begin
            rx_data  = rx_q.pop_front();
            rx_valid = 1'b1;
         end
      end
   end

   // Monitor: samples the read pulse for the receiver and checks every popped byte against the scoreboard.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         #4;
         rd_seen = o_uart_rx_read;
         if (o_uart_rx_read) pulses++;
         if (!reset && !flush && out_read && o_out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL pop_data: got %0h with no byte expected", o_out_data);
            end else begin
               exp = sb.pop_front();
               if (o_out_data !== exp) begin
                  n_errors++;
                  $display("FAIL pop_data: got %0h expected %0h", o_out_data, exp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      out_read = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_level", o_level, 0);
      check("rst_valid", o_out_valid, 0);
      check("rst_read", o_uart_rx_read, 0);
      check("rst_rts", o_fifo_rts, 1);
      check("rst_underflow", o_underflow, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rts_after_release", o_fifo_rts, 0);

      // single byte
      send(8'hA5);
      @(negedge clk);
      check("single_no_pulse_yet", o_uart_rx_read, 0);
      check("single_not_valid_yet", o_out_valid, 0);
      @(negedge clk);
      check("single_pulse", o_uart_rx_read, 1);
      check("single_level", o_level, 1);
      check("single_valid", o_out_valid, 1);
      check("single_data", o_out_data, 8'hA5);
      @(negedge clk);
      check("single_pulse_once", o_uart_rx_read, 0);
      out_read = 1'b1;
      @(negedge clk);
      out_read = 1'b0;
      check("single_level_after_pop", o_level, 0);
      check("single_valid_after_pop", o_out_valid, 0);

      // fill and stall
      pulses = 0;
      for (int b = 1; b <= 5; b++) send(8'(b));
      wait_level(3);
      check("fill_rts_at_3", o_fifo_rts, 1);
      wait_level(4);
      check("fill_rts_at_4", o_fifo_rts, 1);
      repeat (3) @(negedge clk);
      check("fill_level", o_level, 4);
      check("fill_pulses", pulses, 4);
      check("fill_rx_held", rx_valid, 1);
      check("fill_no_pulse", o_uart_rx_read, 0);
      out_read = 1'b1;
      @(negedge clk);
      out_read = 1'b0;
      check("stall_pop_level", o_level, 3);
      @(negedge clk);
      check("stall_refill_level", o_level, 4);
      check("stall_refill_pulse", o_uart_rx_read, 1);
      drain();
      check("fill_drained", o_level, 0);
      check("fill_sb_empty", sb.size(), 0);

      // wrap-around
      send(8'h10);
      send(8'h11);
      wait_level(2);
      lvl_max = 0;
      for (int i = 2; i < 10; i++) begin
         send(8'(16 + i));
         out_read = 1'b1;
         @(negedge clk);
         track_level();
         out_read = 1'b0;
         repeat (3) begin
            @(negedge clk);
            track_level();
         end
      end
      check("wrap_level_max", lvl_max, 2);
      check("wrap_level", o_level, 2);
      drain();
      check("wrap_sb_empty", sb.size(), 0);

      // simultaneous push and pop at level 2
      send(8'h20);
      send(8'h21);
      wait_level(2);
      send(8'h22);
      @(negedge clk);
      check("simul_rx_valid", rx_valid, 1);
      out_read = 1'b1;
      @(negedge clk);
      out_read = 1'b0;
      check("simul_level", o_level, 2);
      check("simul_pulse", o_uart_rx_read, 1);
      check("simul_head", o_out_data, 8'h21);
      drain();
      check("simul_sb_empty", sb.size(), 0);

      // underflow
      out_read = 1'b1;
      @(negedge clk);
      out_read = 1'b0;
      check("uflow_flag", o_underflow, 1);
      check("uflow_level", o_level, 0);
      check("uflow_valid", o_out_valid, 0);
      @(negedge clk);
      check("uflow_sticky", o_underflow, 1);

      // flush with a byte pending in the receiver
      send(8'h31);
      send(8'h32);
      send(8'h33);
      wait_level(3);
      flush = 1'b1;
      sb.delete();
      send(8'h7E);
      repeat (2) @(negedge clk);
      check("flush_level", o_level, 0);
      check("flush_underflow", o_underflow, 0);
      check("flush_valid", o_out_valid, 0);
      check("flush_rts", o_fifo_rts, 0);
      flush = 1'b0;
      @(negedge clk);
      check("flush_after_level", o_level, 1);
      check("flush_after_data", o_out_data, 8'h7E);
      check("flush_after_pulse", o_uart_rx_read, 1);
      drain();
      check("flush_sb_empty", sb.size(), 0);

      // asynchronous reset mid-stream with a read pulse in flight
      send(8'h41);
      send(8'h42);
      send(8'h43);
      wait_level(3);
      check("prereset_pulse", o_uart_rx_read, 1);
      reset = 1'b1;
      #1;
      check("areset_level", o_level, 0);
      check("areset_pulse", o_uart_rx_read, 0);
      check("areset_valid", o_out_valid, 0);
      check("areset_rts", o_fifo_rts, 1);
      check("areset_underflow", o_underflow, 0);
      sb.delete();
      sb.push_back(8'h43);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("retake_rts", o_fifo_rts, 0);
      check("retake_level", o_level, 1);
      check("retake_pulse", o_uart_rx_read, 1);
      check("retake_data", o_out_data, 8'h43);
      repeat (4) @(negedge clk);
      check("retake_once", o_level, 1);
      drain();
      check("final_sb_empty", sb.size(), 0);
      check("final_rx_q_empty", rx_q.size(), 0);
      check("final_level", o_level, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Pops each completed byte from the receiver with a single-cycle read pulse and stores it in a DEPTH-entry FIFO. Presents the bytes to the CPU/peripheral bus through a first-word-fall-through valid/read interface. Drives a flow-control RTS level derived from FIFO occupancy, for combination with the receiver's own RTS.

Parameters:
PAYLOAD_BITS, 8, width of each received byte; matches the receiver payload width.
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
LEVEL_BITS, $clog2(DEPTH)+1, width of the occupancy count (localparam).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
uart_rx_valid  input  1  receiver holds a completed byte.
uart_rx_data  input  PAYLOAD_BITS  byte from the receiver; stable while uart_rx_valid=1.
uart_rx_read  output  1  single-cycle pulse: byte taken, receiver may clear.
flush  input  1  synchronous FIFO clear.
out_data  output  PAYLOAD_BITS  head-of-FIFO byte, valid when out_valid=1.
out_valid  output  1  FIFO not empty.
out_read  input  1  pop strobe from consumer.
level  output  LEVEL_BITS  current occupancy, 0..DEPTH.
fifo_rts  output  1  active-low flow control: 1 = stop sending.
underflow  output  1  sticky error: out_read seen while empty.

Behaviour:
- Reset (async assert, sync release): rd_ptr=wr_ptr=0, level=0, uart_rx_read=0, underflow=0, fifo_rts=1, out_valid=0. out_data content is don't-care while out_valid=0.
- Push decision: push = uart_rx_valid & ~full & ~uart_rx_read & ~flush, where full = (level==DEPTH).
- On push: mem[wr_ptr] <= uart_rx_data, wr_ptr increments modulo DEPTH, and uart_rx_read <= 1 for exactly the next cycle.
- The ~uart_rx_read term blocks a double-take on the cycle the receiver is still showing valid. Each byte is pushed exactly once. The minimum push spacing is 2 cycles.
- Full: no push and no read pulse. The byte waits in the receiver, which holds it; nothing is lost in this block.
- Pop: pop = out_read & out_valid & ~flush. rd_ptr increments modulo DEPTH.
- out_data = mem[rd_ptr] combinationally (first-word fall-through). The first byte appears on out_data/out_valid the cycle after its push edge.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are determined from level, never from pointer equality.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. No other arithmetic.
- Simultaneous events:
  - Push and pop at level=DEPTH cannot occur, because push is gated by the registered full.
  - Pop and push at level=0 cannot occur, because pop is gated by out_valid.
- out_read while out_valid=0: ignored (pointers and level unchanged), and underflow <= 1. underflow holds until flush or reset.
- flush: the next edge sets rd_ptr=wr_ptr=0, level=0 and underflow=0. It blocks push and pop that cycle.
  - A byte pending in the receiver is not read during the flush cycle and is taken afterwards, normally.
  - A uart_rx_read pulse already launched completes normally; its byte was written before the flush and is discarded by it.
- fifo_rts: registered. fifo_rts <= (next level >= DEPTH-1), so it tracks the level update on the same edge. It deasserts to 0 on the first clock after reset release when the FIFO is empty.
- Reset mid-operation: all state clears immediately, including an in-flight uart_rx_read pulse. The receiver's byte remains valid and is re-taken after reset.

Test Plan:
- Single byte: receiver presents 0xA5 at cycle 10 → uart_rx_read=1 only at cycle 11; out_valid=1, out_data=0xA5, level=1 at cycle 11; one out_read → level=0, out_valid=0.
- Fill and stall (DEPTH=4): stream 0x01..0x05 with valid held between bytes → 4 read pulses, level=4, fifo_rts=1 from level 3; 0x05 held by receiver with no pulse. One pop (0x01 out) → 0x05 taken within 2 cycles, level=4; drain yields 0x02,0x03,0x04,0x05 in order.
- Wrap-around: 10 push/pop pairs interleaved at level 1–2 with bytes 0x10..0x19 → output order exact, level never exceeds 2, pointers wrap past 3→0 with no glitch on out_data.
- Simultaneous push/pop at level=2 → level stays 2; popped byte is the oldest; the new byte is appended at the tail.
- Underflow and flush: out_read pulsed at level=0 → underflow=1, level stays 0. Fill to 3 then flush with receiver valid 0x7E → level=0, underflow=0; 0x7E pushed on the cycle after flush; level=1.
- Async reset mid-stream (level=3, read pulse high) → all outputs at reset values immediately, without waiting for a clock; after release the held receiver byte is taken once; fifo_rts=0 after the first clock.
